// File: rtl/instr_decode_queue.sv
// Decoded-instruction queue: decodes each fetch lane on enqueue and issues in order,
// never separating a control-flow instruction from its delay slot across issue cycles.
package instr_decode_queue_pkg;
  typedef logic [31:0] virt_t;

  typedef enum logic [4:0] {
    OP_INVALID = 5'd0,  OP_NOP   = 5'd1,  OP_SLL   = 5'd2,  OP_ADDU = 5'd3,
    OP_SUBU    = 5'd4,  OP_AND   = 5'd5,  OP_OR    = 5'd6,  OP_XOR  = 5'd7,
    OP_SLT     = 5'd8,  OP_JR    = 5'd9,  OP_ADDIU = 5'd10, OP_LW   = 5'd11,
    OP_SW      = 5'd12, OP_BEQ   = 5'd13, OP_BNE   = 5'd14, OP_J    = 5'd15,
    OP_JAL     = 5'd16, OP_ILLEGAL = 5'd17
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        is_controlflow;
  } decoded_instr_t;

  localparam decoded_instr_t INVALID_INSTR = '{op: OP_INVALID, rs: 5'd0, rt: 5'd0,
                                               rd: 5'd0, imm: 16'd0, is_controlflow: 1'b0};
endpackage

module instr_decode_queue_dec
  import instr_decode_queue_pkg::*;
(
  input  logic [31:0]    instr_i,
  output decoded_instr_t dec_o
);
  logic [5:0] opcode_s;
  logic [5:0] funct_s;

  assign opcode_s = instr_i[31:26];
  assign funct_s  = instr_i[5:0];

  // Register fields are passed through raw; only op and control-flow flag are decoded
  always_comb begin
    dec_o.rs             = instr_i[25:21];
    dec_o.rt             = instr_i[20:16];
    dec_o.rd             = instr_i[15:11];
    dec_o.imm            = instr_i[15:0];
    dec_o.is_controlflow = 1'b0;
    dec_o.op             = OP_ILLEGAL;
    case (opcode_s)
      6'h00: begin
        case (funct_s)
          6'h00: dec_o.op = (instr_i == 32'h0000_0000) ? OP_NOP : OP_SLL;
          6'h08: begin dec_o.op = OP_JR; dec_o.is_controlflow = 1'b1; end
          6'h21: dec_o.op = OP_ADDU;
          6'h23: dec_o.op = OP_SUBU;
          6'h24: dec_o.op = OP_AND;
          6'h25: dec_o.op = OP_OR;
          6'h26: dec_o.op = OP_XOR;
          6'h2a: dec_o.op = OP_SLT;
          default: dec_o.op = OP_ILLEGAL;
        endcase
      end
      6'h02: begin dec_o.op = OP_J;   dec_o.is_controlflow = 1'b1; end
      6'h03: begin dec_o.op = OP_JAL; dec_o.is_controlflow = 1'b1; end
      6'h04: begin dec_o.op = OP_BEQ; dec_o.is_controlflow = 1'b1; end
      6'h05: begin dec_o.op = OP_BNE; dec_o.is_controlflow = 1'b1; end
      6'h09: dec_o.op = OP_ADDIU;
      6'h23: dec_o.op = OP_LW;
      6'h2b: dec_o.op = OP_SW;
      default: dec_o.op = OP_ILLEGAL;
    endcase
  end
endmodule

module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  localparam int FN_W  = $clog2(FETCH_WIDTH + 1),
  localparam int ACK_W = $clog2(ISSUE_WIDTH + 1),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               fetch_valid,
  input  logic [FN_W-1:0]                    fetch_num,
  input  virt_t [FETCH_WIDTH-1:0]            fetch_vaddr,
  input  logic [FETCH_WIDTH-1:0][31:0]       fetch_instr,
  output logic                               fetch_ready,
  output logic [ISSUE_WIDTH-1:0]             issue_valid,
  output virt_t [ISSUE_WIDTH-1:0]            issue_vaddr,
  output decoded_instr_t [ISSUE_WIDTH-1:0]   issue_instr,
  input  logic [ACK_W-1:0]                   issue_ack,
  output logic [CNT_W-1:0]                   count
);
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  decoded_instr_t mem_instr_q [DEPTH];
  virt_t          mem_vaddr_q [DEPTH];

  decoded_instr_t [FETCH_WIDTH-1:0] lane_dec_s;
  logic                 enq_s;
  logic [CNT_W-1:0]     enq_num_s;
  logic [ISSUE_WIDTH:0] present_s;
  logic [ISSUE_WIDTH-1:0] slot_cf_s, slot_valid_s;
  logic [CNT_W-1:0]     n_valid_s, ack_min_s, ack_eff_s;
  logic                 split_s;

  for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_dec
    instr_decode_queue_dec u_dec (.instr_i(fetch_instr[l]), .dec_o(lane_dec_s[l]));
  end

  assign fetch_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);

  // Number of lanes written this cycle; oversized fetch_num is clamped to the lane count
  always_comb begin
    enq_s = fetch_valid & fetch_ready & ~flush;
    if (!enq_s) begin
      enq_num_s = '0;
    end else if (fetch_num > FN_W'(FETCH_WIDTH)) begin
      enq_num_s = CNT_W'(FETCH_WIDTH);
    end else begin
      enq_num_s = CNT_W'(fetch_num);
    end
  end

  // Slot validity: a branch without its delay slot in view blocks itself and all later slots
  always_comb begin
    logic blocked_s;
    blocked_s    = 1'b0;
    n_valid_s    = '0;
    present_s    = '0;
    slot_cf_s    = '0;
    slot_valid_s = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      present_s[i] = CNT_W'(i) < count_q;
      slot_cf_s[i] = mem_instr_q[head_q + PTR_W'(i)].is_controlflow;
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (!present_s[i]) begin
        blocked_s = 1'b1;
      end else if ((ISSUE_WIDTH > 1) && slot_cf_s[i] && !present_s[i+1]) begin
        blocked_s = 1'b1;
      end else begin
        blocked_s = blocked_s;
      end
      slot_valid_s[i] = ~blocked_s;
      if (!blocked_s) begin
        n_valid_s = n_valid_s + CNT_W'(1);
      end else begin
        n_valid_s = n_valid_s;
      end
    end
  end

  // Effective acknowledge, pulled back by one if it would strand a delay slot
  always_comb begin
    ack_min_s = (CNT_W'(issue_ack) < n_valid_s) ? CNT_W'(issue_ack) : n_valid_s;
    split_s   = 1'b0;
    for (int k = 1; k < ISSUE_WIDTH; k++) begin
      if ((ack_min_s == CNT_W'(k)) && slot_cf_s[k-1] && slot_valid_s[k]) begin
        split_s = 1'b1;
      end else begin
        split_s = split_s;
      end
    end
    ack_eff_s = split_s ? (ack_min_s - CNT_W'(1)) : ack_min_s;
  end

  // Pointer and occupancy next state
  always_comb begin
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(ack_eff_s);
      tail_d  = tail_q + PTR_W'(enq_num_s);
      count_d = count_q + enq_num_s - ack_eff_s;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written in lane order at the tail
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      if (CNT_W'(l) < enq_num_s) begin
        mem_instr_q[tail_q + PTR_W'(l)] <= lane_dec_s[l];
        mem_vaddr_q[tail_q + PTR_W'(l)] <= fetch_vaddr[l];
      end
    end
  end

  // Issue slot contents
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (slot_valid_s[i]) begin
        issue_instr[i] = mem_instr_q[head_q + PTR_W'(i)];
        issue_vaddr[i] = mem_vaddr_q[head_q + PTR_W'(i)];
      end else begin
        issue_instr[i] = INVALID_INSTR;
        issue_vaddr[i] = 32'h0000_0000;
      end
    end
  end

  assign issue_valid = slot_valid_s;
  assign count       = count_q;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Randomized and directed bench for instr_decode_queue against a queue-based reference model.
module tb_instr_decode_queue;
  import instr_decode_queue_pkg::*;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] W_ADDU = 32'h0022_1821;
  localparam logic [31:0] W_OR   = 32'h0022_2025;
  localparam logic [31:0] W_BEQ  = 32'h1022_0004;
  localparam logic [31:0] W_NOP  = 32'h0000_0000;

  logic clk, rst_n, flush, fetch_valid, fetch_ready;
  logic [1:0] fetch_num, issue_ack;
  virt_t [FW-1:0] fetch_vaddr;
  logic [FW-1:0][31:0] fetch_instr;
  logic [IW-1:0] issue_valid;
  virt_t [IW-1:0] issue_vaddr;
  decoded_instr_t [IW-1:0] issue_instr;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] pc;

  typedef struct {logic [31:0] va; logic [31:0] w;} ent_t;
  ent_t mq[$];

  instr_decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_num(fetch_num), .fetch_vaddr(fetch_vaddr), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .issue_valid(issue_valid), .issue_vaddr(issue_vaddr),
    .issue_instr(issue_instr), .issue_ack(issue_ack), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic decoded_instr_t ref_decode(input logic [31:0] w);
    decoded_instr_t d;
    op_e op;
    logic [5:0] opc, fn;
    opc = w[31:26];
    fn  = w[5:0];
    op  = OP_ILLEGAL;
    if (opc == 6'h00) begin
      if (fn == 6'h00)      op = (w == 32'h0) ? OP_NOP : OP_SLL;
      else if (fn == 6'h08) op = OP_JR;
      else if (fn == 6'h21) op = OP_ADDU;
      else if (fn == 6'h23) op = OP_SUBU;
      else if (fn == 6'h24) op = OP_AND;
      else if (fn == 6'h25) op = OP_OR;
      else if (fn == 6'h26) op = OP_XOR;
      else if (fn == 6'h2a) op = OP_SLT;
    end
    else if (opc == 6'h02) op = OP_J;
    else if (opc == 6'h03) op = OP_JAL;
    else if (opc == 6'h04) op = OP_BEQ;
    else if (opc == 6'h05) op = OP_BNE;
    else if (opc == 6'h09) op = OP_ADDIU;
    else if (opc == 6'h23) op = OP_LW;
    else if (opc == 6'h2b) op = OP_SW;
    d.op = op;
    d.rs = w[25:21];
    d.rt = w[20:16];
    d.rd = w[15:11];
    d.imm = w[15:0];
    d.is_controlflow = (op inside {OP_JR, OP_J, OP_JAL, OP_BEQ, OP_BNE});
    return d;
  endfunction

  function automatic bit is_cf(input logic [31:0] w);
    decoded_instr_t d;
    d = ref_decode(w);
    return d.is_controlflow;
  endfunction

  function automatic int model_nvalid();
    int n;
    n = 0;
    for (int i = 0; i < IW && i < mq.size(); i++) begin
      if (IW > 1 && is_cf(mq[i].w) && (i == IW - 1 || i + 1 >= mq.size())) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit model_ready();
    return (DEPTH - mq.size()) >= FW;
  endfunction

  task automatic check_outputs(input string tag);
    int n;
    decoded_instr_t inv;
    inv = '0;
    inv.op = OP_INVALID;
    n = model_nvalid();
    chk({tag, "_count"}, 64'(count), 64'(mq.size()));
    chk({tag, "_ready"}, 64'(fetch_ready), 64'(model_ready()));
    chk({tag, "_valid"}, 64'(issue_valid), 64'((1 << n) - 1));
    for (int i = 0; i < IW; i++) begin
      if (i < n) begin
        chk($sformatf("%s_slot%0d_instr", tag, i), 64'(issue_instr[i]), 64'(ref_decode(mq[i].w)));
        chk($sformatf("%s_slot%0d_vaddr", tag, i), 64'(issue_vaddr[i]), 64'(mq[i].va));
      end else begin
        chk($sformatf("%s_slot%0d_inv", tag, i), 64'(issue_instr[i]), 64'(inv));
      end
    end
  endtask

  task automatic model_advance(input bit fv, input int fn, input logic [31:0] a0, w0, a1, w1,
                               input int ack, input bit fl);
    int n, eff;
    bit rdy;
    rdy = model_ready();
    n = model_nvalid();
    eff = (ack < n) ? ack : n;
    if (eff > 0 && eff < n && is_cf(mq[eff-1].w)) eff--;
    if (fl) begin
      mq.delete();
    end else begin
      repeat (eff) void'(mq.pop_front());
      if (fv && rdy) begin
        if (fn >= 1) mq.push_back('{va: a0, w: w0});
        if (fn >= 2) mq.push_back('{va: a1, w: w1});
      end
    end
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks the result.
  task automatic step(input string tag, input logic fv, input logic [1:0] fn,
                      input logic [31:0] a0, w0, a1, w1, input logic [1:0] ack, input logic fl);
    flush = fl;
    fetch_valid = fv;
    fetch_num = fn;
    fetch_vaddr[0] = a0;
    fetch_instr[0] = w0;
    fetch_vaddr[1] = a1;
    fetch_instr[1] = w1;
    issue_ack = ack;
    #1;
    chk({tag, "_ready_pre"}, 64'(fetch_ready), 64'(model_ready()));
    model_advance(fv, int'(fn), a0, w0, a1, w1, int'(ack), fl);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic beat(input string tag, input logic [1:0] fn, input logic [1:0] ack);
    step(tag, 1'b1, fn, pc, W_ADDU, pc + 32'd4, W_OR, ack, 1'b0);
    pc = pc + 32'd8;
  endtask

  task automatic idle(input string tag, input logic [1:0] ack);
    step(tag, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, ack, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      1: begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
      2: begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
      3: begin w[31:26] = 6'h00; w[5:0] = 6'h2a; end
      4: w[31:26] = 6'h09;
      5: w[31:26] = 6'h23;
      6: w[31:26] = 6'h04;
      7: w[31:26] = 6'h05;
      8: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      9: w[31:26] = 6'h02;
      10: w = 32'h0;
      default: w = w;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    fetch_valid = 1'b0;
    fetch_num = 2'd0;
    fetch_vaddr = '0;
    fetch_instr = '0;
    issue_ack = 2'd0;
    pc = 32'h0000_5000;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic two-wide issue
    step("r33_beat", 1'b1, 2'd2, 32'h1000, W_ADDU, 32'h1004, W_OR, 2'd0, 1'b0);
    chk("r33_op0", 64'(issue_instr[0].op), 64'(OP_ADDU));
    chk("r33_op1", 64'(issue_instr[1].op), 64'(OP_OR));
    idle("r33_ack", 2'd2);
    chk("r33_empty", 64'(count), 64'd0);

    // Branch and delay slot retire together
    step("r34_beat", 1'b1, 2'd2, 32'h2000, W_BEQ, 32'h2004, W_NOP, 2'd0, 1'b0);
    idle("r34_ack1", 2'd1);
    chk("r34_hold", 64'(count), 64'd2);
    idle("r34_ack2", 2'd2);

    // Branch waits for its delay slot
    step("r35_beat", 1'b1, 2'd2, 32'h3000, W_ADDU, 32'h3004, W_BEQ, 2'd0, 1'b0);
    chk("r35_v01", 64'(issue_valid), 64'b01);
    step("r35_ds", 1'b1, 2'd1, 32'h3008, W_NOP, 32'h0, 32'h0, 2'd1, 1'b0);
    chk("r35_v11", 64'(issue_valid), 64'b11);
    chk("r35_pc0", 64'(issue_vaddr[0]), 64'h3004);
    idle("r35_drain", 2'd2);

    // Near-full backpressure, ready lags the ack by one cycle, pointer wrap
    beat("r36_f1", 2'd2, 2'd0);
    beat("r36_f2", 2'd2, 2'd0);
    beat("r36_f3", 2'd2, 2'd0);
    beat("r36_f4", 2'd1, 2'd0);
    chk("r36_full_ready", 64'(fetch_ready), 64'd0);
    beat("r36_ackfull", 2'd2, 2'd2);
    chk("r36_ready_rise", 64'(fetch_ready), 64'd1);
    idle("r36_d1", 2'd2);
    idle("r36_d2", 2'd2);
    idle("r36_d3", 2'd1);

    // Flush discards queue and same-cycle beat
    beat("r37_f1", 2'd2, 2'd0);
    beat("r37_f2", 2'd2, 2'd0);
    beat("r37_f3", 2'd1, 2'd0);
    step("r37_flush", 1'b1, 2'd2, 32'h7000, W_ADDU, 32'h7004, W_OR, 2'd2, 1'b1);
    chk("r37_count", 64'(count), 64'd0);
    idle("r37_after", 2'd0);

    // Asynchronous reset mid-operation
    beat("r38_f1", 2'd2, 2'd0);
    beat("r38_f2", 2'd2, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("r38_count", 64'(count), 64'd0);
    chk("r38_valid", 64'(issue_valid), 64'd0);
    chk("r38_ready", 64'(fetch_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    beat("r38_post", 2'd2, 2'd0);
    chk("r38_accept", 64'(count), 64'd2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [31:0] w0, w1;
      w0 = rand_instr();
      w1 = rand_instr();
      step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)), pc, w0,
           pc + 32'd4, w1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 24) == 0));
      pc = pc + 32'd8;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_decode_queue.md
INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, SHALL set the number of instructions offered per fetch beat (1..4).
REQ-002 Parameter ISSUE_WIDTH, default 2, SHALL set the number of decoded instructions presented per cycle (1..4).
REQ-003 Parameter DEPTH, default 8, SHALL set the queue entry count; it SHALL be a power of 2 and at least FETCH_WIDTH+ISSUE_WIDTH.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 flush  in  1  discard all queued and incoming instructions.
REQ-007 fetch_valid  in  1  fetch beat present.
REQ-008 fetch_num  in  $clog2(FETCH_WIDTH+1)  count of valid lanes in the beat, lanes 0..fetch_num-1.
REQ-009 fetch_vaddr  in  FETCH_WIDTH x 32  per-lane virt_t PC.
REQ-010 fetch_instr  in  FETCH_WIDTH x 32  per-lane instruction word.
REQ-011 fetch_ready  out  1  high when free entries >= FETCH_WIDTH.
REQ-012 issue_valid  out  ISSUE_WIDTH  per-slot valid, always contiguous from slot 0.
REQ-013 issue_vaddr  out  ISSUE_WIDTH x 32  PC of each slot.
REQ-014 issue_instr  out  ISSUE_WIDTH x decoded_instr_t  decoded fields of each slot.
REQ-015 issue_ack  in  $clog2(ISSUE_WIDTH+1)  number of slots consumed this cycle, counted from slot 0.
REQ-016 count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-017 Each fetch lane SHALL be decoded by its own decoder instance at enqueue, and the decoded_instr_t SHALL be stored with vaddr.
REQ-018 Enqueue SHALL occur when fetch_valid & fetch_ready & ~flush; fetch_num entries SHALL be written in lane order at the tail, wrapping modulo DEPTH.
REQ-019 An instruction enqueued at edge t SHALL be visible on issue slots from cycle t+1; there SHALL be no combinational fetch-to-issue path.
REQ-020 Slot i SHALL present the entry at head+i (mod DEPTH) when i < count, subject to REQ-021.
REQ-021 Delay-slot pairing: if slot i holds an entry with is_controlflow=1, and either i = ISSUE_WIDTH-1 or entry head+i+1 is absent, slot i and all higher slots SHALL be invalid.
REQ-022 With ISSUE_WIDTH = 1, pairing SHALL NOT apply; a branch SHALL issue alone.
REQ-023 The effective acknowledge SHALL be min(issue_ack, number of valid slots). If that value splits a branch from its delay slot (slot k-1 is controlflow and slot k is valid), the ack SHALL be reduced by one.
REQ-024 The head SHALL advance by the effective ack, wrapping modulo DEPTH.
REQ-025 Simultaneous enqueue and dequeue SHALL update count to count + enq - ack in one cycle; count SHALL never exceed DEPTH or go below 0.
REQ-026 fetch_ready SHALL be computed from the registered count only and SHALL NOT depend on issue_ack in the same cycle.
REQ-027 When fetch_valid=1, fetch_num=0 SHALL be a no-op.
REQ-028 flush SHALL set head, tail, and count to 0 at the next edge. The same-cycle fetch beat and issue_ack SHALL be ignored. issue_valid SHALL be 0 in the following cycle.
REQ-029 Entry contents SHALL NOT require reset; only the pointers and count are state.
REQ-030 Invalid slots SHALL drive issue_instr.op = OP_INVALID and all other fields to 0.

Reset
REQ-031 While rst_n=0, asynchronously: head=0, tail=0, count=0, issue_valid=0, fetch_ready=1.
REQ-032 Reset asserted mid-operation SHALL drop all queued entries with no partial issue. The first post-release edge SHALL accept a fetch beat.

Verification
REQ-033 Reset, then beat {0x1000: addu, 0x1004: or} -> next cycle issue_valid=2'b11, ops OP_ADDU/OP_OR, count=2. Then ack=2 -> count=0.
REQ-034 Beat {0x2000: beq, 0x2004: nop}, ack=1 -> effective ack 0, count stays 2. Then ack=2 -> both retire together.
REQ-035 Beat with lane0=addu, lane1=beq, delay slot not yet fetched -> issue_valid=2'b01. Fetch the delay slot, then slot0=beq and slot1=delay, issue_valid=2'b11.
REQ-036 Fill to count=7 with DEPTH=8 -> fetch_ready=0. Same-cycle ack=2 -> fetch_ready stays 0 that cycle, rises next cycle. Pointer wrap across entry 7 to 0 preserves order.
REQ-037 count=5 with fetch_valid=1 and flush=1 -> count=0 next cycle, issue_valid=0, and no entries from the flushed beat appear.
REQ-038 rst_n pulsed low at count=4 -> outputs at reset values immediately, before any clock edge.
